// File: rtl/perceptron_batch_ctrl.sv
// Perceptron neuron sequencer: reduces NUM_BATCHES beats of LANES operands, accumulates, thresholds.
// Optional fire statistics counter enabled by defining PERCEPTRON_FIRE_STATS_EN.
module perceptron_batch_ctrl #(
    parameter int              OP_W        = 3,
    parameter int              LANES       = 12,
    parameter int              NUM_BATCHES = 4,
    parameter int              ACC_W       = 10,
    parameter logic [ACC_W-1:0] THRESH_INIT = 10'd100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*OP_W-1:0]   in_data,
    input  logic                    cfg_we,
    input  logic [ACC_W-1:0]        cfg_thresh,
    output logic                    cfg_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_sum,
    output logic                    out_fire,
    output logic                    busy,
    output logic [15:0]             fire_cnt,
    output logic [1:0]              dbg_state
);

    localparam int SUM_W = $clog2(LANES * (2**OP_W - 1) + 1);
    localparam int CNT_W = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_BATCH = CNT_W'(NUM_BATCHES - 1);

    typedef enum logic [1:0] {ST_ACCUM = 2'd0, ST_DRAIN = 2'd1, ST_RESULT = 2'd2} state_t;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // a producer holds valid and payload stable until that edge.

    // Carry-save reduction: each stage turns every group of 3 operands into sum + carry,
    // passing leftovers through, until two operands remain for one final add.
    function automatic logic [SUM_W-1:0] batch_sum_f(input logic [LANES*OP_W-1:0] d);
        logic [SUM_W-1:0] v [LANES];
        logic [SUM_W-1:0] a, b, c;
        int n, m, idx;
        for (int k = 0; k < LANES; k++) v[k] = SUM_W'(d[k*OP_W +: OP_W]);
        n = LANES;
        for (int s = 0; s < LANES; s++) begin
            if (n > 2) begin
                m = 0;
                for (int g = 0; g < LANES / 3; g++) begin
                    if (3 * g + 2 < n) begin
                        a = v[IDX_W'(3 * g)];
                        b = v[IDX_W'(3 * g + 1)];
                        c = v[IDX_W'(3 * g + 2)];
                        v[IDX_W'(m)]     = a ^ b ^ c;
                        v[IDX_W'(m + 1)] = ((a & b) | (a & c) | (b & c)) << 1;
                        m = m + 2;
                    end
                end
                for (int r = 0; r < 2; r++) begin
                    idx = 3 * (n / 3) + r;
                    if (idx < n) begin
                        v[IDX_W'(m)] = v[IDX_W'(idx)];
                        m = m + 1;
                    end
                end
                n = m;
            end
        end
        return (n > 1) ? v[0] + v[1] : v[0];
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   batch_cnt_q, batch_cnt_d;
    logic [SUM_W-1:0]   psum_q, psum_d;
    logic               pv_q, pv_d;
    logic               plast_q, plast_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   thresh_q, thresh_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_fire_q, out_fire_d;
    logic               out_valid_q, out_valid_d;
    logic               cfg_err_q, cfg_err_d;
    logic               beat_acc;
    logic               cfg_ok;
    logic               res_hs;
    logic [ACC_W-1:0]   total;

    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == ST_ACCUM);
        beat_acc = in_valid & in_ready;
        res_hs   = out_valid_q & out_ready;
        unique case (state_q)
            ST_ACCUM:  if (beat_acc && batch_cnt_q == LAST_BATCH) state_d = ST_DRAIN;
            ST_DRAIN:  state_d = ST_RESULT;
            ST_RESULT: if (res_hs) state_d = ST_ACCUM;
            default:   state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        batch_cnt_d = batch_cnt_q;
        psum_d      = psum_q;
        pv_d        = 1'b0;
        plast_d     = plast_q;
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        out_fire_d  = out_fire_q;
        out_valid_d = out_valid_q;
        total       = acc_q + ACC_W'(psum_q);

        if (beat_acc) begin
            psum_d      = batch_sum_f(in_data);
            pv_d        = 1'b1;
            plast_d     = (batch_cnt_q == LAST_BATCH);
            batch_cnt_d = (batch_cnt_q == LAST_BATCH) ? '0 : batch_cnt_q + CNT_W'(1);
        end

        if (pv_q && !plast_q) acc_d = total;

        if (state_q == ST_DRAIN) begin
            out_sum_d   = total;
            out_fire_d  = (total >= thresh_q);
            out_valid_d = 1'b1;
            acc_d       = '0;
        end else if (state_q == ST_RESULT && res_hs) begin
            out_valid_d = 1'b0;
        end

        // Threshold may only change between neurons so a result never mixes two thresholds.
        cfg_ok    = (state_q == ST_ACCUM) && (batch_cnt_q == '0) && !pv_q;
        thresh_d  = (cfg_we && cfg_ok) ? cfg_thresh : thresh_q;
        cfg_err_d = cfg_we & ~cfg_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            batch_cnt_q <= '0;
            psum_q      <= '0;
            pv_q        <= 1'b0;
            plast_q     <= 1'b0;
            acc_q       <= '0;
            thresh_q    <= THRESH_INIT;
            out_sum_q   <= '0;
            out_fire_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            batch_cnt_q <= batch_cnt_d;
            psum_q      <= psum_d;
            pv_q        <= pv_d;
            plast_q     <= plast_d;
            acc_q       <= acc_d;
            thresh_q    <= thresh_d;
            out_sum_q   <= out_sum_d;
            out_fire_q  <= out_fire_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

`ifdef PERCEPTRON_FIRE_STATS_EN
    logic [15:0] fire_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fire_cnt_q <= '0;
        end else if (res_hs && out_fire_q && fire_cnt_q != 16'hFFFF) begin
            fire_cnt_q <= fire_cnt_q + 16'd1;
        end
    end

    assign fire_cnt = fire_cnt_q;
`else
    assign fire_cnt = 16'h0000;
`endif

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_fire  = out_fire_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = (batch_cnt_q != '0) | pv_q | (state_q != ST_ACCUM);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_perceptron_batch_ctrl.sv
// Directed testbench for perceptron_batch_ctrl; hand-computed sums and fire bits.
module tb_perceptron_batch_ctrl;

    localparam int OP_W  = 3;
    localparam int LANES = 12;
    localparam int ACC_W = 10;
    localparam int DW    = LANES * OP_W;

    localparam logic [DW-1:0] ALL7  = 36'hFFFFFFFFF;  // 84 per beat
    localparam logic [DW-1:0] ALL1  = 36'h249249249;  // 12 per beat
    localparam logic [DW-1:0] EQ16  = 36'h0000000BF;  // 7+7+2 = 16
    localparam logic [DW-1:0] EQ15  = 36'h00000007F;  // 7+7+1 = 15
    localparam logic [DW-1:0] ZERO  = 36'h000000000;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             cfg_we;
    logic [ACC_W-1:0] cfg_thresh;
    logic             cfg_err;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_fire;
    logic             busy;
    logic [15:0]      fire_cnt;
    logic [1:0]       dbg_state;

    int total;
    int bad;

    perceptron_batch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .cfg_we     (cfg_we),
        .cfg_thresh (cfg_thresh),
        .cfg_err    (cfg_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_fire   (out_fire),
        .busy       (busy),
        .fire_cnt   (fire_cnt),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: four back-to-back beats; returns just after the edge accepting the last one
    task automatic drive_beats(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                               input logic [DW-1:0] b2, input logic [DW-1:0] b3);
        logic [DW-1:0] beats [4];
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = beats[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic write_thresh(input logic [ACC_W-1:0] t);
        cfg_we     = 1'b1;
        cfg_thresh = t;
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (out_sum !== 10'd0) begin bad++; $display("FAIL rst_out_sum: got %0d want 0", out_sum); end
        total++; if (out_fire !== 1'b0) begin bad++; $display("FAIL rst_out_fire: got %b want 0", out_fire); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (fire_cnt !== 16'd0) begin bad++; $display("FAIL rst_fire_cnt: got %0d want 0", fire_cnt); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive_beats(ALL7, ALL7, ALL7, ALL7);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_drain_ready: got %b want 0", in_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_drain_busy: got %b want 1", busy); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_result_ready: got %b want 0", in_ready); end
        total++; if (out_sum !== 10'd336) begin bad++; $display("FAIL basic_sum: got %0d want 336", out_sum); end
        total++; if (out_fire !== 1'b1) begin bad++; $display("FAIL basic_fire: got %b want 1", out_fire); end
        total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL basic_state: got %0d want 2", dbg_state); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_hs_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_hs_ready: got %b want 1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_hs_busy: got %b want 0", busy); end
    endtask

    task automatic test_equality();
        drive_beats(ALL7, EQ16, ZERO, ZERO);
        tick();
        total++; if (out_sum !== 10'd100) begin bad++; $display("FAIL eq_sum: got %0d want 100", out_sum); end
        total++; if (out_fire !== 1'b1) begin bad++; $display("FAIL eq_fire: got %b want 1", out_fire); end
        tick();
        drive_beats(ALL7, EQ15, ZERO, ZERO);
        tick();
        total++; if (out_sum !== 10'd99) begin bad++; $display("FAIL eq_minus1_sum: got %0d want 99", out_sum); end
        total++; if (out_fire !== 1'b0) begin bad++; $display("FAIL eq_minus1_fire: got %b want 0", out_fire); end
        tick();
    endtask

    task automatic test_zero_thresh();
        write_thresh(10'd0);
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL zt_cfg_err: got %b want 0", cfg_err); end
        drive_beats(ZERO, ZERO, ZERO, ZERO);
        tick();
        total++; if (out_sum !== 10'd0) begin bad++; $display("FAIL zt_sum: got %0d want 0", out_sum); end
        total++; if (out_fire !== 1'b1) begin bad++; $display("FAIL zt_fire: got %b want 1", out_fire); end
        tick();
        write_thresh(10'd1);
        drive_beats(ZERO, ZERO, ZERO, ZERO);
        tick();
        total++; if (out_fire !== 1'b0) begin bad++; $display("FAIL zt1_fire: got %b want 0", out_fire); end
        tick();
        write_thresh(10'd100);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] junk;
        out_ready = 1'b0;
        drive_beats(ALL7, ALL7, ALL7, ALL7);
        tick();
        for (int i = 0; i < 5; i++) begin
            junk     = ALL1 ^ DW'(i * 36'h123456789);
            in_valid = 1'b1;
            in_data  = junk;
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            total++; if (out_sum !== 10'd336) begin bad++; $display("FAIL bp_sum[%0d]: got %0d want 336", i, out_sum); end
            total++; if (out_fire !== 1'b1) begin bad++; $display("FAIL bp_fire[%0d]: got %b want 1", i, out_fire); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
        end
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_release_busy: got %b want 0", busy); end
        drive_beats(ALL1, ALL1, ALL1, ALL1);
        tick();
        total++; if (out_sum !== 10'd48) begin bad++; $display("FAIL bp_next_sum: got %0d want 48", out_sum); end
        total++; if (out_fire !== 1'b0) begin bad++; $display("FAIL bp_next_fire: got %b want 0", out_fire); end
        tick();
    endtask

    task automatic test_cfg();
        in_valid = 1'b1; in_data = ALL7; tick();
        in_data = ZERO; tick();
        in_valid = 1'b0;
        write_thresh(10'd50);
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_rej_err: got %b want 1", cfg_err); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL cfg_rej_busy: got %b want 1", busy); end
        tick();
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_rej_pulse: got %b want 0", cfg_err); end
        in_valid = 1'b1; in_data = ZERO; tick();
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (out_sum !== 10'd84) begin bad++; $display("FAIL cfg_rej_sum: got %0d want 84", out_sum); end
        total++; if (out_fire !== 1'b0) begin bad++; $display("FAIL cfg_rej_fire: got %b want 0", out_fire); end
        tick();
        // write together with beat 0 is accepted and applies to this neuron
        cfg_we = 1'b1; cfg_thresh = 10'd50;
        in_valid = 1'b1; in_data = ALL7; tick();
        cfg_we = 1'b0;
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_acc_err: got %b want 0", cfg_err); end
        in_data = ZERO; tick(); tick(); tick();
        in_valid = 1'b0;
        tick();
        total++; if (out_sum !== 10'd84) begin bad++; $display("FAIL cfg_acc_sum: got %0d want 84", out_sum); end
        total++; if (out_fire !== 1'b1) begin bad++; $display("FAIL cfg_acc_fire: got %b want 1", out_fire); end
        tick();
        write_thresh(10'd100);
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_data = ALL7; tick(); tick();
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #2;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
        total++; if (out_sum !== 10'd0) begin bad++; $display("FAIL rm_out_sum: got %0d want 0", out_sum); end
        total++; if (out_fire !== 1'b0) begin bad++; $display("FAIL rm_out_fire: got %b want 0", out_fire); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", busy); end
        total++; if (fire_cnt !== 16'd0) begin bad++; $display("FAIL rm_fire_cnt: got %0d want 0", fire_cnt); end
        tick();
        reset = 1'b0;
        drive_beats(ALL1, ALL1, ALL1, ALL1);
        tick();
        total++; if (out_sum !== 10'd48) begin bad++; $display("FAIL rm_next_sum: got %0d want 48", out_sum); end
        total++; if (out_fire !== 1'b0) begin bad++; $display("FAIL rm_next_fire: got %b want 0", out_fire); end
        tick();
    endtask

    task automatic test_fire_stats();
        for (int n = 0; n < 3; n++) begin
            drive_beats(ALL7, ALL7, ALL7, ALL7);
            tick();
            tick();
        end
`ifdef PERCEPTRON_FIRE_STATS_EN
        total++; if (fire_cnt !== 16'd3) begin bad++; $display("FAIL fs_three: got %0d want 3", fire_cnt); end
`else
        total++; if (fire_cnt !== 16'd0) begin bad++; $display("FAIL fs_tied: got %0d want 0", fire_cnt); end
`endif
        drive_beats(ZERO, ZERO, ZERO, ZERO);
        tick();
        tick();
`ifdef PERCEPTRON_FIRE_STATS_EN
        total++; if (fire_cnt !== 16'd3) begin bad++; $display("FAIL fs_nofire: got %0d want 3", fire_cnt); end
`else
        total++; if (fire_cnt !== 16'd0) begin bad++; $display("FAIL fs_tied_nofire: got %0d want 0", fire_cnt); end
`endif
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        cfg_we     = 1'b0;
        cfg_thresh = '0;
        out_ready  = 1'b1;
        #3;
        test_reset();
        tick();
        tick();
        reset = 1'b0;
        test_basic();
        test_equality();
        test_zero_thresh();
        test_backpressure();
        test_cfg();
        test_reset_mid();
        test_fire_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
